ring_code_decoder: RTL
======================

// Module: ring_code_decoder
// PURPOSE
//  Receive-side companion to the 8-bit one-hot ring counter. Samples a one-hot ring code each
//  valid cycle and decodes it to a binary index. Checks that the code is one-hot and that it
//  advances by exactly one position per sample. Tracks lock state and counts errors.
//  Placed wherever a ring-counter phase bus crosses into logic that needs a binary index.
// PARAMETERS
//  WIDTH      8  ring length in bits; index width IW = $clog2(WIDTH)
//  DIR        0  0: code rotates left (index+1 mod WIDTH); 1: rotates right (index-1 mod WIDTH)
//  LOCK_CNT   3  consecutive good transitions required to enter LOCKED (>=1)
//  ERR_CNT_W  8  width of saturating error counter
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          ring_in is sampled this cycle
//  ring_in    in   WIDTH      one-hot ring code
//  idx_out    out  IW         decoded index of last good sample
//  idx_valid  out  1          one-cycle pulse: idx_out updated
//  onehot_err out  1          one-cycle pulse: sample was zero or had >1 bit set
//  seq_err    out  1          one-cycle pulse: one-hot sample broke the sequence while LOCKED
//  locked     out  1          high while in LOCKED
//  err_count  out  ERR_CNT_W  saturating count of onehot_err + seq_err events
// BEHAVIOUR
//  - Reset (async, immediate): all outputs 0, state HUNT, have_prev=0, match_cnt=0, prev=0.
//  - All outputs are registered. Latency is 1 cycle from the in_valid sample to its outputs.
//  - in_valid=0: idx_valid, onehot_err and seq_err are 0. State, prev and counters hold.
//  - Decode: popcount(ring_in)==1 is a good sample; index = position of the set bit.
//    ring_in 0x00 or any multi-bit value -> onehot_err.
//  - Expected index = prev+1 mod WIDTH (DIR=0) or prev-1 mod WIDTH (DIR=1).
//    With DIR=0, 0x80 (idx 7) -> 0x01 (idx 0) is a legal wrap.
//  - Bad sample, any state:
//    onehot_err=1; idx_valid=0; idx_out holds; have_prev=0; match_cnt=0; state->HUNT;
//    err_count+1.
//  - Good sample:
//    idx_out=index; idx_valid=1; prev=index; have_prev=1.
//  - HUNT, good sample:
//    if have_prev and index==expected: match_cnt+1.
//    Otherwise: match_cnt=0 and no seq_err.
//    When match_cnt reaches LOCK_CNT: state->LOCKED. locked rises in the same output cycle.
//  - LOCKED, good sample:
//    index==expected: stay LOCKED.
//    Otherwise (including a repeated index): seq_err=1; state->HUNT; match_cnt=0;
//    err_count+1. prev still updates to the new index.
//  - err_count saturates at 2^ERR_CNT_W-1 and never wraps.
//    At most one increment per cycle: onehot_err and seq_err are mutually exclusive.
//  - locked == (state==LOCKED). Reset mid-stream drops locked immediately; HUNT restarts after.
// STRUCTURE
//  - Shared package ring_pkg holds:
//    state typedef {HUNT, LOCKED};
//    default WIDTH constant;
//    function next_idx(idx, dir, width).
//  - One combinational sub-module, ring_onehot_decode (ring_in -> is_onehot, index).
//  - Top level holds the state register, prev/have_prev, match_cnt, err_count and output regs.
// TESTING
//  1 Lock-up, DIR=0, LOCK_CNT=3: samples 0x80,0x01,0x02,0x04 on consecutive cycles
//    -> idx_out 7,0,1,2; locked rises with idx_out=2; no error pulses.
//  2 Wrap: while LOCKED, feed 0x40,0x80,0x01
//    -> idx 6,7,0; seq_err stays 0; locked stays 1.
//  3 One-hot faults while LOCKED: 0x00, then 0x03
//    -> onehot_err pulses twice; idx_valid=0 on both; locked falls; err_count=2.
//  4 Skip while LOCKED: 0x01 then 0x04
//    -> seq_err pulse with idx_out=2; locked falls; err_count+1.
//    Then 0x08,0x10,0x20 -> relock at idx 5.
//  5 Saturation, ERR_CNT_W=2: five 0x00 samples -> err_count 1,2,3,3,3.
//  6 Async reset asserted mid-cycle while LOCKED
//    -> all outputs 0 before the next clk edge; relock needs LOCK_CNT good steps after release.
//    Repeat test 1 with DIR=1 and sequence 0x01,0x80,0x40,0x20.

Source files
------------

// File: rtl/ring_pkg.sv
// ring_pkg: shared types, defaults and index-stepping helper for the ring-code decoder
package ring_pkg;

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam int WIDTH_DEF = 8;

    // Index the ring code should show on the next sample (dir 0 rotates left, 1 rotates right)
    function automatic int next_idx(input int idx, input int dir, input int width);
        if (dir == 0)
            return (idx == width - 1) ? 0 : idx + 1;
        return (idx == 0) ? width - 1 : idx - 1;
    endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// ring_onehot_decode: combinational one-hot check and bit-position decode of a ring code
//   ring_in   in   WIDTH  ring code sample
//   is_onehot out  1      exactly one bit of ring_in is set
//   index     out  IW     position of the set bit (meaningful only when is_onehot)
import ring_pkg::*;

module ring_onehot_decode #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] ring_in,
    output logic             is_onehot,
    output logic [IW-1:0]    index
);

    logic [IW:0] cnt;

    always_comb begin
        cnt   = '0;
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt   = cnt + (IW+1)'(ring_in[i]);
            index = ring_in[i] ? IW'(i) : index;
        end
        is_onehot = (cnt == (IW+1)'(1));
    end

endmodule

// File: rtl/ring_code_decoder.sv
// ring_code_decoder: decodes a one-hot ring code to a binary index, checks sequence, tracks lock
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   in_valid   in   1          ring_in is sampled this cycle
//   ring_in    in   WIDTH      one-hot ring code
//   idx_out    out  IW         decoded index of last good sample
//   idx_valid  out  1          pulse: idx_out updated
//   onehot_err out  1          pulse: sample was zero or multi-bit
//   seq_err    out  1          pulse: good sample broke the sequence while locked
//   locked     out  1          high while in LOCKED
//   err_count  out  ERR_CNT_W  saturating error count
import ring_pkg::*;

module ring_code_decoder #(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DIR       = 0,
    parameter int LOCK_CNT  = 3,
    parameter int ERR_CNT_W = 8,
    parameter int IW        = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     ring_in,
    output logic [IW-1:0]        idx_out,
    output logic                 idx_valid,
    output logic                 onehot_err,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    state_t               state, state_n;
    logic [IW-1:0]        prev, prev_n, idx_n, index, expected;
    logic                 have_prev, have_prev_n, is_onehot, in_seq;
    logic                 idx_valid_n, onehot_err_n, seq_err_n, err_inc;
    logic [MW-1:0]        match_cnt, match_n;
    logic [ERR_CNT_W-1:0] err_n;

    ring_onehot_decode #(.WIDTH(WIDTH), .IW(IW)) u_dec (
        .ring_in  (ring_in),
        .is_onehot(is_onehot),
        .index    (index)
    );

    assign expected = IW'(next_idx(int'(prev), DIR, WIDTH));
    assign in_seq   = have_prev && (index == expected);
    assign locked   = (state == LOCKED);

    always_comb begin
        state_n      = state;
        prev_n       = prev;
        have_prev_n  = have_prev;
        match_n      = match_cnt;
        idx_n        = idx_out;
        idx_valid_n  = 1'b0;
        onehot_err_n = 1'b0;
        seq_err_n    = 1'b0;
        err_inc      = 1'b0;
        if (in_valid && !is_onehot) begin
            onehot_err_n = 1'b1;
            have_prev_n  = 1'b0;
            match_n      = '0;
            state_n      = HUNT;
            err_inc      = 1'b1;
        end else if (in_valid) begin
            idx_n       = index;
            idx_valid_n = 1'b1;
            prev_n      = index;
            have_prev_n = 1'b1;
            if (state == LOCKED && !in_seq) begin
                seq_err_n = 1'b1;
                state_n   = HUNT;
                match_n   = '0;
                err_inc   = 1'b1;
            end else if (state == HUNT) begin
                match_n = in_seq ? match_cnt + 1'b1 : '0;
                state_n = (match_n == MW'(LOCK_CNT)) ? LOCKED : HUNT;
            end
        end
        err_n = (err_inc && err_count != '1) ? err_count + 1'b1 : err_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            prev       <= '0;
            have_prev  <= 1'b0;
            match_cnt  <= '0;
            idx_out    <= '0;
            idx_valid  <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            have_prev  <= have_prev_n;
            match_cnt  <= match_n;
            idx_out    <= idx_n;
            idx_valid  <= idx_valid_n;
            onehot_err <= onehot_err_n;
            seq_err    <= seq_err_n;
            err_count  <= err_n;
        end
    end

endmodule
